// File: rtl/four_bits_counter_monitor_if.sv
// Monitor-side bundle for four_bits_counter_monitor: sampled counter inputs and status outputs.
// err_count only exists when FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN is defined.
interface four_bits_counter_monitor_if #(
  parameter int WRAP_W = 8
);
  logic [3:0]        counter;
  logic              overflow;
  logic              clear;
  logic              locked;
  logic              err_pulse;
  logic              err_sticky;
  logic [WRAP_W-1:0] wrap_count;
  logic [3:0]        expected;
`ifdef FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  modport master (
`ifdef FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN
    input  err_count,
`endif
    output counter, overflow, clear,
    input  locked, err_pulse, err_sticky, wrap_count, expected
  );

  modport slave (
`ifdef FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN
    output err_count,
`endif
    input  counter, overflow, clear,
    output locked, err_pulse, err_sticky, wrap_count, expected
  );
endinterface

// File: rtl/four_bits_counter_monitor.sv
// Protocol monitor for an upstream 4-bit wrapping counter: locks after LOCK_COUNT good samples,
// flags violations once locked, counts wraps. Optional err_count via FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN.
module four_bits_counter_monitor #(
  parameter int LOCK_COUNT = 3,
  parameter int WRAP_W     = 8
) (
  input  logic clk,
  input  logic reset,
  four_bits_counter_monitor_if.slave mon
);
  typedef enum logic [1:0] {SYNC, LOCKING, LOCKED} state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

  state_t            state, state_nxt;
  logic [3:0]        prev, run, run_nxt, run_inc;
  logic              good, err_det, wrap_det;
  logic              locked_q, err_pulse_q, err_sticky_q;
  logic [WRAP_W-1:0] wrap_q;
  logic [3:0]        expected_q;

  // A held value fails the increment test, so it is bad like any other skip.
  assign good    = (mon.counter == prev + 4'd1) && (mon.overflow == (mon.counter == 4'hF));
  assign run_inc = run + 4'd1;

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    err_det   = 1'b0;
    wrap_det  = 1'b0;
    case (state)
      SYNC: begin
        run_nxt   = 4'd0;
        state_nxt = LOCKING;
      end
      LOCKING: begin
        if (good) begin
          run_nxt = run_inc;
          if (run_inc >= LOCK_RUN) state_nxt = LOCKED;
        end else begin
          run_nxt = 4'd0;
        end
      end
      LOCKED: begin
        if (good) begin
          wrap_det = (prev == 4'hF);
        end else begin
          err_det   = 1'b1;
          state_nxt = SYNC;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev         <= 4'd0;
      run          <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_q       <= '0;
      expected_q   <= 4'h1;
    end else begin
      prev        <= mon.counter;
      run         <= run_nxt;
      locked_q    <= (state_nxt == LOCKED);
      err_pulse_q <= err_det;
      expected_q  <= mon.counter + 4'd1;
      // A coincident error beats clear for the sticky flag; clear beats a wrap.
      if (err_det)        err_sticky_q <= 1'b1;
      else if (mon.clear) err_sticky_q <= 1'b0;
      if (mon.clear)                      wrap_q <= '0;
      else if (wrap_det && wrap_q != '1)  wrap_q <= wrap_q + 1'b1;
    end
  end

`ifdef FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || mon.clear)               err_cnt_q <= 8'd0;
    else if (err_det && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign mon.err_count = err_cnt_q;
`endif

  assign mon.locked     = locked_q;
  assign mon.err_pulse  = err_pulse_q;
  assign mon.err_sticky = err_sticky_q;
  assign mon.wrap_count = wrap_q;
  assign mon.expected   = expected_q;
endmodule

// File: tb/tb_four_bits_counter_monitor.sv
// Directed vector bench for four_bits_counter_monitor (LOCK_COUNT=3, WRAP_W=8).
module tb_four_bits_counter_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  four_bits_counter_monitor_if #(.WRAP_W(8)) bus ();

  four_bits_counter_monitor #(.LOCK_COUNT(3), .WRAP_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (bus.slave)
  );

  typedef struct {
    logic       rst, clr, ovf;
    logic [3:0] cnt;
    logic       lck, ep, es;
    logic [7:0] wc;
    logic [3:0] ex;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(input logic rst, clr, ovf, input logic [3:0] cnt,
                              input logic lck, ep, es, input logic [7:0] wc, input logic [3:0] ex);
    vec_t v;
    v.rst = rst; v.clr = clr; v.ovf = ovf; v.cnt = cnt;
    v.lck = lck; v.ep = ep; v.es = es; v.wc = wc; v.ex = ex;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, clr, ovf, input logic [3:0] cnt);
    @(negedge clk);
    reset = rst; bus.clear = clr; bus.overflow = ovf; bus.counter = cnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.counter = 4'd0; bus.overflow = 1'b0; bus.clear = 1'b0;

    // reset, then clean run from 0: lock after the third good sample
    add(1,0,0,4'd0, 0,0,0,8'd0,4'd1);
    add(1,0,0,4'd0, 0,0,0,8'd0,4'd1);
    add(0,0,0,4'd0, 0,0,0,8'd0,4'd1);
    add(0,0,0,4'd1, 0,0,0,8'd0,4'd2);
    add(0,0,0,4'd2, 0,0,0,8'd0,4'd3);
    add(0,0,0,4'd3, 1,0,0,8'd0,4'd4);
    for (int i = 4; i <= 51; i++)
      add(0,0,(i%16)==15,4'(i%16), 1,0,0,8'((i>=16)+(i>=32)+(i>=48)),4'((i+1)%16));
    // skip 3->5, resync
    add(0,0,0,4'd5, 0,1,1,8'd3,4'd6);
    add(0,0,0,4'd3, 0,0,1,8'd3,4'd4);
    add(0,0,0,4'd4, 0,0,1,8'd3,4'd5);
    add(0,0,0,4'd5, 0,0,1,8'd3,4'd6);
    add(0,0,0,4'd6, 1,0,1,8'd3,4'd7);
    // overflow with counter 7
    add(0,0,1,4'd7, 0,1,1,8'd3,4'd8);
    add(0,0,0,4'd11,0,0,1,8'd3,4'd12);
    add(0,0,0,4'd12,0,0,1,8'd3,4'd13);
    add(0,0,0,4'd13,0,0,1,8'd3,4'd14);
    add(0,0,0,4'd14,1,0,1,8'd3,4'd15);
    // counter 15 without overflow
    add(0,0,0,4'd15,0,1,1,8'd3,4'd0);
    add(0,0,0,4'd0, 0,0,1,8'd3,4'd1);
    add(0,0,0,4'd1, 0,0,1,8'd3,4'd2);
    add(0,0,0,4'd1, 0,0,1,8'd3,4'd2);  // held while locking: no error
    add(0,0,0,4'd2, 0,0,1,8'd3,4'd3);
    add(0,0,0,4'd3, 0,0,1,8'd3,4'd4);
    add(0,0,0,4'd4, 1,0,1,8'd3,4'd5);
    add(0,0,0,4'd4, 0,1,1,8'd3,4'd5);  // held while locked: error
    add(0,0,0,4'd0, 0,0,1,8'd3,4'd1);
    add(0,0,0,4'd1, 0,0,1,8'd3,4'd2);
    add(0,0,0,4'd2, 0,0,1,8'd3,4'd3);
    add(0,0,0,4'd3, 1,0,1,8'd3,4'd4);
    // mid-run reset, then no error on resync
    add(1,0,0,4'd4, 0,0,0,8'd0,4'd1);
    add(0,0,0,4'd14,0,0,0,8'd0,4'd15);
    add(0,0,1,4'd15,0,0,0,8'd0,4'd0);
    add(0,0,0,4'd0, 0,0,0,8'd0,4'd1);  // wrap while locking is not counted
    add(0,0,0,4'd1, 1,0,0,8'd0,4'd2);
    for (int c = 2; c <= 15; c++) add(0,0,c==15,4'(c), 1,0,0,8'd0,4'((c+1)%16));
    add(0,0,0,4'd0, 1,0,0,8'd1,4'd1);
    add(0,1,0,4'd1, 1,0,0,8'd0,4'd2);  // clear leaves lock alone
    for (int c = 2; c <= 15; c++) add(0,0,c==15,4'(c), 1,0,0,8'd0,4'((c+1)%16));
    add(0,1,0,4'd0, 1,0,0,8'd0,4'd1);  // clear wins over wrap
    add(0,0,0,4'd1, 1,0,0,8'd0,4'd2);
    add(0,1,0,4'd3, 0,1,1,8'd0,4'd4);  // error wins over clear for sticky
    add(0,1,0,4'd4, 0,0,0,8'd0,4'd5);

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].rst, vq[k].clr, vq[k].ovf, vq[k].cnt);
      chk("locked",     k, 32'(bus.locked),     32'(vq[k].lck));
      chk("err_pulse",  k, 32'(bus.err_pulse),  32'(vq[k].ep));
      chk("err_sticky", k, 32'(bus.err_sticky), 32'(vq[k].es));
      chk("wrap_count", k, 32'(bus.wrap_count), 32'(vq[k].wc));
      chk("expected",   k, 32'(bus.expected),   32'(vq[k].ex));
    end

`ifdef FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN
    chk("err_count_cleared", 0, 32'(bus.err_count), 32'h0);
    for (int e = 0; e < 300; e++) begin
      drive(0,0,0,4'd0);
      drive(0,0,0,4'd1);
      drive(0,0,0,4'd2);
      drive(0,0,0,4'd3);
      drive(0,0,0,4'd9);
      if (e == 0) chk("err_count_first", e, 32'(bus.err_count), 32'h1);
    end
    chk("err_count_sat", 300, 32'(bus.err_count), 32'hFF);
    drive(0,1,0,4'd0);
    chk("err_count_clear", 301, 32'(bus.err_count), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/four_bits_counter_monitor.md
FOUR_BITS_COUNTER_MONITOR -- requirements
Module: four_bits_counter_monitor

Interface
REQ-001 Parameter: LOCK_COUNT, default 3; consecutive good samples needed to declare lock (range 1..15).
REQ-002 Parameter: WRAP_W, default 8; width of wrap_count.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: counter  input  4  sampled value from the upstream four-bit counter.
REQ-006 Port: overflow  input  1  upstream overflow flag; legal only while counter == 4'hF.
REQ-007 Port: clear  input  1  synchronous clear of err_sticky and wrap_count.
REQ-008 Port: locked  output  1  high while the monitor is in state LOCKED.
REQ-009 Port: err_pulse  output  1  one-cycle pulse per detected protocol violation.
REQ-010 Port: err_sticky  output  1  set by any err_pulse; held until reset or clear.
REQ-011 Port: wrap_count  output  WRAP_W  number of 15->0 wraps observed while LOCKED, saturating.
REQ-012 Port: expected  output  4  next counter value the monitor predicts.

Function
REQ-013 The monitor SHALL sample counter and overflow on every rising clk edge and keep a registered copy prev of the last sample.
REQ-014 A sample SHALL be "good" when counter == (prev + 1) mod 16 and overflow == (counter == 4'hF); otherwise it is "bad".
REQ-015 States: SYNC, LOCKING, LOCKED; a 4-bit run counter counts consecutive good samples.
REQ-016 SYNC: capture the sample into prev, clear run, go to LOCKING next cycle; no errors flagged.
REQ-017 LOCKING: good sample -> run + 1, go to LOCKED when run reaches LOCK_COUNT; bad sample -> run = 0, stay LOCKING, no error flagged.
REQ-018 LOCKED: good sample -> stay; bad sample -> err_pulse high next cycle, err_sticky set, state -> SYNC.
REQ-019 Outputs locked, err_pulse and expected SHALL be registered, with one-cycle latency from the sampling edge.
REQ-020 expected SHALL equal (prev + 1) mod 16, i.e. 4'hF wraps to 4'h0.
REQ-021 wrap_count SHALL increment by 1 when a good sample of 4'h0 follows prev == 4'hF in LOCKED, and saturate at all-ones.
REQ-022 clear SHALL zero err_sticky and wrap_count next cycle without affecting state, run or locked; when an error or wrap occurs in the same cycle as clear, clear wins for wrap_count and err_sticky is set (the error wins).
REQ-023 A held counter value (no increment) SHALL be treated as a bad sample.

Reset
REQ-024 While reset is high at a rising edge: state = SYNC, prev = 0, run = 0, locked = 0, err_pulse = 0, err_sticky = 0, wrap_count = 0, expected = 4'h1.
REQ-025 Asserting reset mid-operation SHALL abandon lock immediately; no err_pulse SHALL be generated by the reset or by the first sample after it.

Configuration
REQ-026 Macro FOUR_BITS_COUNTER_MONITOR_ERRCNT_EN, when defined, SHALL add output err_count (8 bits): it increments on each err_pulse, saturates at 8'hFF, is zeroed by reset and clear, and when clear and an error coincide it reads 0 after that cycle.
REQ-027 Without the macro, err_count SHALL NOT exist, and all other behaviour is identical.

Verification
REQ-028 Reset for 2 cycles, then a clean 0,1,2,... sequence with overflow at 15 -> locked rises 1 cycle after the 3rd good sample, and err_sticky stays 0.
REQ-029 Locked and running 40 clean cycles from 0 -> wrap_count == 2 and expected tracks counter + 1.
REQ-030 While locked, inject counter 5 after 3 (a skip) -> err_pulse high for exactly 1 cycle, err_sticky = 1, locked = 0, then lock is regained after LOCK_COUNT good samples.
REQ-031 While locked, drive overflow = 1 with counter = 7 -> err_pulse, then SYNC; with counter = 15 and overflow = 0 -> err_pulse.
REQ-032 Locked, with wrap_count = 3, err_sticky = 1; assert reset for 1 cycle mid-run -> all outputs are at their reset values and no err_pulse follows.
REQ-033 Assert clear on the same cycle as a 15->0 wrap -> wrap_count = 0 and err_sticky = 0; with the macro defined, 300 injected errors -> err_count = 8'hFF.
